// File: rtl/i2c_pkg.sv
// Shared encodings for the I2C slave receive path: FSM states, general-call address, ACK bit values.
package i2c_pkg;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_ADDR   = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_ACK    = 3'd3;
  localparam logic [2:0] ST_TX     = 3'd4;
  localparam logic [2:0] ST_IGNORE = 3'd5;

  localparam logic [6:0] GENERAL_CALL_ADDR = 7'h00;

  localparam logic ACK  = 1'b0;
  localparam logic NACK = 1'b1;

endpackage

// File: rtl/i2c_slave_rx_assembler.sv
// Assembles serial bits from the byte reader into address/data bytes, decodes the address,
// buffers one data byte for the register file and requests ACK/NACK from the ACK-write stage.
module i2c_slave_rx_assembler
  import i2c_pkg::*;
#(
  parameter logic [6:0] SLAVE_ADDR      = 7'h50,
  parameter bit         GENERAL_CALL_EN = 1'b1
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       scl,
  input  logic       start_detected,
  input  logic       stop_detected,
  input  logic       bit_data,
  input  logic       bit_load,
  input  logic       byte_finish,
  input  logic       byte_error,
  output logic       byte_enable,
  output logic       ack_request,
  output logic       ack_value,
  input  logic       ack_done,
  output logic       addr_match,
  output logic       rw,
  output logic       tx_start,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       overrun,
  input  logic       overrun_clear,
  output logic       bus_error,
  output logic       busy
);

  logic [2:0] state;
  logic [2:0] next_state;
  logic [6:0] sr;          // only the 7 most recent bits are ever needed to form a byte
  logic       armed;
  logic       scl_last;
  logic       scl_rise;
  logic [7:0] cur_byte;
  logic       addr_hit;
  logic       buf_free;

  assign scl_rise = !scl_last && scl;
  assign cur_byte = {sr, bit_data};
  assign addr_hit = (cur_byte[7:1] == SLAVE_ADDR) ||
                    (GENERAL_CALL_EN && (cur_byte == {GENERAL_CALL_ADDR, 1'b0}));
  assign buf_free = !rx_valid || rx_ready;
  assign busy     = (state != ST_IDLE);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state       <= ST_IDLE;
      next_state  <= ST_IDLE;
      sr          <= 7'h00;
      armed       <= 1'b0;
      scl_last    <= 1'b1;
      byte_enable <= 1'b0;
      ack_request <= 1'b0;
      ack_value   <= 1'b0;
      addr_match  <= 1'b0;
      rw          <= 1'b0;
      tx_start    <= 1'b0;
      rx_data     <= 8'h00;
      rx_valid    <= 1'b0;
      overrun     <= 1'b0;
      bus_error   <= 1'b0;
    end else begin
      scl_last    <= scl;
      byte_enable <= 1'b0;
      ack_request <= 1'b0;
      tx_start    <= 1'b0;
      bus_error   <= 1'b0;

      // Later assignments in this block (new byte, overrun set) override these clears.
      if (rx_valid && rx_ready) rx_valid <= 1'b0;
      if (overrun_clear)        overrun  <= 1'b0;

      if (stop_detected) begin
        state      <= ST_IDLE;
        addr_match <= 1'b0;
        armed      <= 1'b0;
      end else if (start_detected) begin
        state      <= ST_ADDR;
        armed      <= 1'b1;
        addr_match <= 1'b0;
      end else begin
        case (state)
          ST_ADDR, ST_DATA: begin
            if (armed && scl_rise) begin
              byte_enable <= 1'b1;
              armed       <= 1'b0;
            end
            if (byte_error) begin
              bus_error <= 1'b1;
              state     <= ST_IGNORE;
            end else begin
              if (bit_load) sr <= cur_byte[6:0];
              if (byte_finish) begin
                if (state == ST_ADDR) begin
                  if (addr_hit) begin
                    addr_match  <= 1'b1;
                    rw          <= cur_byte[0];
                    ack_request <= 1'b1;
                    ack_value   <= ACK;
                    next_state  <= cur_byte[0] ? ST_TX : ST_DATA;
                    state       <= ST_ACK;
                  end else begin
                    state <= ST_IGNORE;
                  end
                end else begin
                  ack_request <= 1'b1;
                  state       <= ST_ACK;
                  if (buf_free) begin
                    rx_data    <= cur_byte;
                    rx_valid   <= 1'b1;
                    ack_value  <= ACK;
                    next_state <= ST_DATA;
                  end else begin
                    overrun    <= 1'b1;
                    ack_value  <= NACK;
                    next_state <= ST_IGNORE;
                  end
                end
              end
            end
          end
          ST_ACK: begin
            if (ack_done) begin
              state <= next_state;
              if (next_state == ST_DATA) armed    <= 1'b1;
              if (next_state == ST_TX)   tx_start <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2c_slave_rx_assembler.sv
// Directed and randomized bench for i2c_slave_rx_assembler with a transaction-level reference model.
module tb_i2c_slave_rx_assembler;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic       scl = 1'b1;
  logic       start_detected = 1'b0;
  logic       stop_detected = 1'b0;
  logic       bit_data = 1'b0;
  logic       bit_load = 1'b0;
  logic       byte_finish = 1'b0;
  logic       byte_error = 1'b0;
  logic       ack_done = 1'b0;
  logic       rx_ready = 1'b0;
  logic       overrun_clear = 1'b0;

  logic       byte_enable, ack_request, ack_value, addr_match, rw, tx_start;
  logic [7:0] rx_data;
  logic       rx_valid, overrun, bus_error, busy;

  logic       byte_enable2, ack_request2, ack_value2, addr_match2, rw2, tx_start2;
  logic [7:0] rx_data2;
  logic       rx_valid2, overrun2, bus_error2, busy2;

  int tests = 0;
  int failed = 0;

  always #5 clock = ~clock;

  i2c_slave_rx_assembler dut (
    .clock(clock), .reset_n(reset_n), .scl(scl),
    .start_detected(start_detected), .stop_detected(stop_detected),
    .bit_data(bit_data), .bit_load(bit_load), .byte_finish(byte_finish), .byte_error(byte_error),
    .byte_enable(byte_enable), .ack_request(ack_request), .ack_value(ack_value), .ack_done(ack_done),
    .addr_match(addr_match), .rw(rw), .tx_start(tx_start),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .overrun(overrun), .overrun_clear(overrun_clear), .bus_error(bus_error), .busy(busy)
  );

  i2c_slave_rx_assembler #(.SLAVE_ADDR(7'h50), .GENERAL_CALL_EN(1'b0)) dut_nogc (
    .clock(clock), .reset_n(reset_n), .scl(scl),
    .start_detected(start_detected), .stop_detected(stop_detected),
    .bit_data(bit_data), .bit_load(bit_load), .byte_finish(byte_finish), .byte_error(byte_error),
    .byte_enable(byte_enable2), .ack_request(ack_request2), .ack_value(ack_value2), .ack_done(ack_done),
    .addr_match(addr_match2), .rw(rw2), .tx_start(tx_start2),
    .rx_data(rx_data2), .rx_valid(rx_valid2), .rx_ready(rx_ready),
    .overrun(overrun2), .overrun_clear(overrun_clear), .bus_error(bus_error2), .busy(busy2)
  );

  task automatic chk1(input string tag, input logic obs, input logic exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed 0x%02h expected 0x%02h", tag, obs, exp);
    end
  endtask

  // Address decode rule stated directly: 7-bit address match, or general call write.
  function automatic logic addressed(input logic [7:0] b, input bit gc_en);
    return (b[7:1] == 7'h50) || (gc_en && (b == 8'h00));
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic pulse_start();
    start_detected = 1'b1; tick(); start_detected = 1'b0;
  endtask

  task automatic pulse_stop();
    stop_detected = 1'b1; tick(); stop_detected = 1'b0;
  endtask

  task automatic do_ack();
    ack_done = 1'b1; tick(); ack_done = 1'b0;
  endtask

  task automatic consume();
    rx_ready = 1'b1; tick(); rx_ready = 1'b0;
  endtask

  // rdy_mode: 0 = rx_ready low, 1 = high for the whole byte, 2 = high only on the final bit.
  task automatic send_byte(input logic [7:0] b, input int rdy_mode);
    for (int i = 7; i >= 0; i--) begin
      bit_data    = b[i];
      bit_load    = 1'b1;
      byte_finish = (i == 0);
      rx_ready    = (rdy_mode == 1) || (rdy_mode == 2 && i == 0);
      tick();
    end
    bit_load = 1'b0; byte_finish = 1'b0; rx_ready = 1'b0; bit_data = 1'b0;
  endtask

  task automatic scl_pulse(output logic be_on, output logic be_off);
    scl = 1'b0; tick();
    scl = 1'b1; tick();
    be_on = byte_enable;
    tick();
    be_off = byte_enable;
  endtask

  initial begin
    logic [7:0] d;
    logic [7:0] b;
    logic       rdy, be_on, be_off;
    logic       m_valid, m_ovr, in_data;
    logic [7:0] m_data;

    repeat (3) tick();
    chk1("reset_busy", busy, 1'b0);
    chk1("reset_ack_request", ack_request, 1'b0);
    chk1("reset_addr_match", addr_match, 1'b0);
    chk1("reset_rx_valid", rx_valid, 1'b0);
    chk8("reset_rx_data", rx_data, 8'h00);
    chk1("reset_overrun", overrun, 1'b0);
    chk1("reset_byte_enable", byte_enable, 1'b0);
    reset_n = 1'b1;
    tick();

    // Write to our address, then one data byte
    pulse_start();
    scl_pulse(be_on, be_off);
    chk1("addr_byte_enable_on", be_on, 1'b1);
    chk1("addr_byte_enable_off", be_off, 1'b0);
    send_byte(8'hA0, 0);
    chk1("wr_ack_request", ack_request, 1'b1);
    chk1("wr_ack_value", ack_value, 1'b0);
    chk1("wr_addr_match", addr_match, 1'b1);
    chk1("wr_rw", rw, 1'b0);
    do_ack();
    chk1("wr_no_tx_start", tx_start, 1'b0);
    scl_pulse(be_on, be_off);
    chk1("data_byte_enable_on", be_on, 1'b1);
    send_byte(8'h3C, 0);
    chk1("wr_data_ack_request", ack_request, 1'b1);
    chk1("wr_data_ack_value", ack_value, 1'b0);
    chk8("wr_rx_data", rx_data, 8'h3C);
    chk1("wr_rx_valid", rx_valid, 1'b1);
    do_ack();

    // Random data bytes with random consumer readiness against a one-entry buffer model
    m_valid = 1'b1; m_data = 8'h3C; m_ovr = 1'b0; in_data = 1'b1;
    for (int n = 0; n < 16; n++) begin
      if (!in_data) begin
        pulse_start(); send_byte(8'hA0, 0); do_ack(); in_data = 1'b1;
      end
      d   = 8'($urandom);
      rdy = 1'($urandom_range(0, 1));
      send_byte(d, rdy ? 1 : 0);
      if (!m_valid || rdy) begin
        m_valid = 1'b1; m_data = d;
        chk1("rnd_ack_value", ack_value, 1'b0);
      end else begin
        m_ovr = 1'b1; in_data = 1'b0;
        chk1("rnd_ack_value", ack_value, 1'b1);
      end
      chk1("rnd_ack_request", ack_request, 1'b1);
      chk8("rnd_rx_data", rx_data, m_data);
      chk1("rnd_rx_valid", rx_valid, m_valid);
      chk1("rnd_overrun", overrun, m_ovr);
      do_ack();
      if (m_ovr && $urandom_range(0, 1) == 1) begin
        overrun_clear = 1'b1; tick(); overrun_clear = 1'b0;
        m_ovr = 1'b0;
        chk1("rnd_overrun_clear", overrun, 1'b0);
      end
    end
    pulse_stop();
    overrun_clear = 1'b1; tick(); overrun_clear = 1'b0;

    // Address mismatch
    consume();
    pulse_start();
    send_byte(8'hA2, 0);
    chk1("nomatch_ack_request", ack_request, 1'b0);
    chk1("nomatch_busy", busy, 1'b1);
    send_byte(8'h55, 0);
    chk1("nomatch_data_ack_request", ack_request, 1'b0);
    chk1("nomatch_rx_valid", rx_valid, 1'b0);
    scl_pulse(be_on, be_off);
    chk1("nomatch_byte_enable", be_on, 1'b0);
    pulse_stop();
    chk1("stop_busy", busy, 1'b0);

    // Master read
    pulse_start();
    send_byte(8'hA1, 0);
    chk1("rd_ack_request", ack_request, 1'b1);
    chk1("rd_ack_value", ack_value, 1'b0);
    chk1("rd_rw", rw, 1'b1);
    do_ack();
    chk1("rd_tx_start_on", tx_start, 1'b1);
    tick();
    chk1("rd_tx_start_off", tx_start, 1'b0);
    send_byte(8'hFF, 0);
    chk1("rd_bits_ignored", ack_request, 1'b0);
    pulse_stop();

    // Repeated START while waiting for ack_done, then general call
    pulse_start();
    send_byte(8'hA0, 0);
    pulse_start();
    chk1("rs_addr_match", addr_match, 1'b0);
    chk1("rs_busy", busy, 1'b1);
    scl_pulse(be_on, be_off);
    chk1("rs_byte_enable", be_on, 1'b1);
    send_byte(8'h00, 0);
    chk1("gc_ack_request", ack_request, 1'b1);
    chk1("gc_ack_value", ack_value, 1'b0);
    chk1("gc_addr_match", addr_match, 1'b1);
    chk1("gc_disabled_ack_request", ack_request2, 1'b0);
    chk1("gc_disabled_addr_match", addr_match2, 1'b0);
    do_ack();
    pulse_stop();

    // Random address bytes on both instances
    for (int n = 0; n < 8; n++) begin
      b = 8'($urandom);
      if ($urandom_range(0, 1) == 1) b[7:1] = 7'h50;
      if (n == 0) b = 8'h00;
      pulse_start();
      send_byte(b, 0);
      chk1("rnd_addr_ack", ack_request, addressed(b, 1'b1));
      chk1("rnd_addr_ack_nogc", ack_request2, addressed(b, 1'b0));
      pulse_stop();
    end

    // byte_error mid data byte
    pulse_start(); send_byte(8'hA0, 0); do_ack();
    for (int i = 0; i < 3; i++) begin
      bit_data = 1'b1; bit_load = 1'b1; tick();
    end
    bit_load = 1'b0; byte_error = 1'b1; tick(); byte_error = 1'b0;
    chk1("err_bus_error_on", bus_error, 1'b1);
    chk1("err_no_ack", ack_request, 1'b0);
    tick();
    chk1("err_bus_error_off", bus_error, 1'b0);
    send_byte(8'h5A, 0);
    chk1("err_after_ignored", ack_request, 1'b0);
    pulse_stop();

    // Directed overrun, then rx_ready coincident with byte_finish on a full buffer
    pulse_start(); send_byte(8'hA0, 0); do_ack();
    send_byte(8'h11, 0); do_ack();
    send_byte(8'h22, 0);
    chk1("ovr_ack_value", ack_value, 1'b1);
    chk1("ovr_overrun", overrun, 1'b1);
    chk8("ovr_rx_data", rx_data, 8'h11);
    do_ack();
    overrun_clear = 1'b1; tick(); overrun_clear = 1'b0;
    chk1("ovr_clear", overrun, 1'b0);
    pulse_start(); send_byte(8'hA0, 0); do_ack();
    send_byte(8'h77, 2);
    chk1("coinc_ack_value", ack_value, 1'b0);
    chk8("coinc_rx_data", rx_data, 8'h77);
    chk1("coinc_rx_valid", rx_valid, 1'b1);
    chk1("coinc_overrun", overrun, 1'b0);
    do_ack();

    // Asynchronous reset mid-byte
    for (int i = 0; i < 3; i++) begin
      bit_data = 1'b0; bit_load = 1'b1; tick();
    end
    bit_load = 1'b0;
    #2 reset_n = 1'b0;
    #1;
    chk1("arst_rx_valid", rx_valid, 1'b0);
    chk8("arst_rx_data", rx_data, 8'h00);
    chk1("arst_addr_match", addr_match, 1'b0);
    chk1("arst_busy", busy, 1'b0);
    #10 reset_n = 1'b1;
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
